vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator directly upstream of the colour-pattern logic: divides CLK to a pixel strobe, walks horizontal/vertical counters through active, front-porch, sync and back-porch phases, and emits HS, VS, pixel coordinates and blanking/marker signals. The downstream pattern stage compares x/y against rectangle bounds and drives RED/GREEN/BLUE; ACTIVE lets it blank colour outside the visible area. Default timing is 640x480@60 Hz from a 50 MHz CLK.

## Interface
- CLK_DIV, 2: CLK cycles per pixel, ≥1
- H_ACTIVE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal phase lengths in pixels; H_TOTAL = sum = 800, must be ≤1024
- V_ACTIVE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical phase lengths in lines; V_TOTAL = 525, ≤1024
- HS_POL, 0 / VS_POL, 0: asserted sync level (0 = active-low)

- CLK  in  1  system clock
- RST_N  in  1  reset; asynchronous, active-low
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- x  out  10  current column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- ACTIVE  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- PIX_EN  out  1  one-CLK pixel strobe
- LINE_START  out  1  one-CLK pulse when x becomes 0
- FRAME_START  out  1  one-CLK pulse when (x,y) becomes (0,0)
- FRAME_CNT  out  8  frames started since reset, wraps 255→0

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 every CLK; PIX_EN registered, high for exactly one CLK per CLK_DIV CLKs. CLK_DIV=1: PIX_EN continuously high after first edge post-reset.
- Position advances only on edges where PIX_EN=1. x increments; at H_TOTAL-1 wraps to 0 and y increments; y at V_TOTAL-1 wraps to 0 on the same edge.
- Horizontal FSM H_ACT→H_FP→H_SYNC→H_BP→H_ACT; phase change on the strobe where the phase counter reaches its length-1. Vertical FSM V_ACT→V_FP→V_SYNC→V_BP→V_ACT, stepped only on the H_BP→H_ACT transition.
- HS = HS_POL while in H_SYNC (x 656..751 default), else ~HS_POL. VS likewise in V_SYNC (y 490..491).
- HS, VS, ACTIVE, x, y are all registered and mutually aligned: every value describes the same pixel.
- LINE_START/FRAME_START registered, high for the single CLK following the advancing edge; FRAME_CNT increments on that same edge.
- Reset (RST_N low, any time, asynchronous): div_cnt=0, PIX_EN=0, position = (H_TOTAL-1, V_TOTAL-1) i.e. x=799, y=524, FSMs in H_BP/V_BP, HS=~HS_POL, VS=~VS_POL, ACTIVE=0, LINE_START=FRAME_START=0, FRAME_CNT=0. First strobe after release therefore advances to (0,0) and fires LINE_START, FRAME_START and FRAME_CNT→1.

## Timing
- First PIX_EN: high in the cycle after the CLK_DIV-th rising edge following reset release.
- Outputs change only on PIX_EN edges (markers drop on the next CLK); stable for CLK_DIV CLKs.
- Latency decode→output: 0 pixels (registered from next-state, no skew between x and HS/ACTIVE).
- Line period H_TOTAL strobes; frame period H_TOTAL·V_TOTAL = 420000 strobes (840000 CLK default).
- Reset mid-frame restarts cleanly; no partial sync pulse beyond the reset edge.

## Structure
- Shared package vga_timing_pkg: default 640x480 phase-length constants, phase enum (ACT, FP, SYNC, BP), coordinate width constant 10.
- One sub-module: vga_pix_strobe (CLK_DIV divider producing PIX_EN, async active-low reset).
- Two FSM instances share the phase enum; counters and decoding in vga_sync_gen.

## Test plan
- Hold RST_N low 5 CLK → x=799, y=524, HS=VS=1, ACTIVE=0, PIX_EN=0, FRAME_CNT=0.
- Release reset, CLK_DIV=2 → PIX_EN every 2nd CLK; first strobe gives x=0,y=0, ACTIVE=1, LINE_START=FRAME_START=1 for 1 CLK, FRAME_CNT=1.
- Run one line → HS low for exactly 96 strobes starting at x=656; ACTIVE low from x=640; x 799→0 with y 0→1 and LINE_START.
- Run one frame → VS low only for y=490..491 (1600 strobes); y 524→0, FRAME_START, FRAME_CNT=2 after second frame start.
- CLK_DIV=1 → PIX_EN constant high, line = 800 CLK.
- Assert RST_N mid-line at x=300,y=200 → all outputs return to reset values immediately (asynchronously); after release, next strobe → (0,0) with FRAME_START.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and the phase enum used by both sync FSMs.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FRONT_D  = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BACK_D   = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FRONT_D  = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BACK_D   = 33;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ACT:     next_phase = FP;
      FP:      next_phase = SYNC;
      SYNC:    next_phase = BP;
      default: next_phase = ACT;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle handed from the sync generator to the pattern stage.
interface vga_sync_gen_if;

  logic                                HS;
  logic                                VS;
  logic [vga_timing_pkg::COORD_W-1:0]  x;
  logic [vga_timing_pkg::COORD_W-1:0]  y;
  logic                                ACTIVE;
  logic                                PIX_EN;
  logic                                LINE_START;
  logic                                FRAME_START;
  logic [7:0]                          FRAME_CNT;

  modport master (
    output HS, VS, x, y, ACTIVE, PIX_EN, LINE_START, FRAME_START, FRAME_CNT
  );

  modport slave (
    input HS, VS, x, y, ACTIVE, PIX_EN, LINE_START, FRAME_START, FRAME_CNT
  );

endinterface

// File: rtl/vga_pix_strobe.sv
// Divides CLK by CLK_DIV into a registered one-CLK pixel strobe.
module vga_pix_strobe #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  output logic PIX_EN
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      PIX_EN  <= 1'b0;
    end else begin
      PIX_EN  <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel strobe, H/V phase FSMs, position counters and
// registered sync/blanking/marker outputs, all describing the same pixel.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FRONT  = H_FRONT_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BACK   = H_BACK_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FRONT  = V_FRONT_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BACK   = V_BACK_D,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic           CLK,
  input  logic           RST_N,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

  function automatic logic [COORD_W-1:0] h_len_m1(input phase_t p);
    case (p)
      ACT:     h_len_m1 = COORD_W'(H_ACTIVE - 1);
      FP:      h_len_m1 = COORD_W'(H_FRONT - 1);
      SYNC:    h_len_m1 = COORD_W'(H_SYNC - 1);
      default: h_len_m1 = COORD_W'(H_BACK - 1);
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] v_len_m1(input phase_t p);
    case (p)
      ACT:     v_len_m1 = COORD_W'(V_ACTIVE - 1);
      FP:      v_len_m1 = COORD_W'(V_FRONT - 1);
      SYNC:    v_len_m1 = COORD_W'(V_SYNC - 1);
      default: v_len_m1 = COORD_W'(V_BACK - 1);
    endcase
  endfunction

  logic               pix_en;
  phase_t             h_st, h_nxt, v_st, v_nxt;
  logic [COORD_W-1:0] h_pc, hpc_nxt, v_pc, vpc_nxt;
  logic [COORD_W-1:0] x_p0, x_nxt, y_p0, y_nxt;
  logic               line_step;
  logic               line_nxt, frame_nxt;
  logic               hs_p0, vs_p0, active_p0, line_p0, frame_p0;
  logic [7:0]         fcnt_p0;

  vga_pix_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .PIX_EN (pix_en)
  );

  always_comb begin
    h_nxt     = h_st;
    hpc_nxt   = h_pc;
    line_step = 1'b0;
    if (pix_en) begin
      if (h_pc == h_len_m1(h_st)) begin
        h_nxt     = next_phase(h_st);
        hpc_nxt   = '0;
        line_step = (h_st == BP);
      end else begin
        hpc_nxt = h_pc + 1'b1;
      end
    end
  end

  // Vertical FSM only moves on the back-porch-to-active line boundary
  always_comb begin
    v_nxt   = v_st;
    vpc_nxt = v_pc;
    if (line_step) begin
      if (v_pc == v_len_m1(v_st)) begin
        v_nxt   = next_phase(v_st);
        vpc_nxt = '0;
      end else begin
        vpc_nxt = v_pc + 1'b1;
      end
    end
  end

  always_comb begin
    x_nxt     = x_p0;
    y_nxt     = y_p0;
    line_nxt  = 1'b0;
    frame_nxt = 1'b0;
    if (pix_en) begin
      if (x_p0 == X_LAST) begin
        x_nxt    = '0;
        line_nxt = 1'b1;
        if (y_p0 == Y_LAST) begin
          y_nxt     = '0;
          frame_nxt = 1'b1;
        end else begin
          y_nxt = y_p0 + 1'b1;
        end
      end else begin
        x_nxt = x_p0 + 1'b1;
      end
    end
  end

  // Outputs decode the next state so x/y and HS/VS/ACTIVE land together
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_st      <= BP;
      h_pc      <= COORD_W'(H_BACK - 1);
      v_st      <= BP;
      v_pc      <= COORD_W'(V_BACK - 1);
      x_p0      <= X_LAST;
      y_p0      <= Y_LAST;
      hs_p0     <= ~HS_POL;
      vs_p0     <= ~VS_POL;
      active_p0 <= 1'b0;
      line_p0   <= 1'b0;
      frame_p0  <= 1'b0;
      fcnt_p0   <= '0;
    end else begin
      h_st      <= h_nxt;
      h_pc      <= hpc_nxt;
      v_st      <= v_nxt;
      v_pc      <= vpc_nxt;
      x_p0      <= x_nxt;
      y_p0      <= y_nxt;
      hs_p0     <= (h_nxt == SYNC) ? HS_POL : ~HS_POL;
      vs_p0     <= (v_nxt == SYNC) ? VS_POL : ~VS_POL;
      active_p0 <= (h_nxt == ACT) && (v_nxt == ACT);
      line_p0   <= line_nxt;
      frame_p0  <= frame_nxt;
      fcnt_p0   <= fcnt_p0 + {7'd0, frame_nxt};
    end
  end

  assign vga.HS          = hs_p0;
  assign vga.VS          = vs_p0;
  assign vga.x           = x_p0;
  assign vga.y           = y_p0;
  assign vga.ACTIVE      = active_p0;
  assign vga.PIX_EN      = pix_en;
  assign vga.LINE_START  = line_p0;
  assign vga.FRAME_START = frame_p0;
  assign vga.FRAME_CNT   = fcnt_p0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing at CLK_DIV=2, plus a CLK_DIV=1 unit
// with a shortened vertical raster so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;

  vga_sync_gen_if va();
  vga_sync_gen_if vb();

  vga_sync_gen #(.CLK_DIV(2)) dut_a (
    .CLK   (clk),
    .RST_N (rst_a),
    .vga   (va)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .V_ACTIVE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .CLK   (clk),
    .RST_N (rst_b),
    .vga   (vb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n, hs_low, hs_first, hs_err, act_err;
    int pz, vs_low, vs_err, ls_cnt, ls1, ls2, act_cnt, y_last;

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rst_x",      va.x, 799);
    chk("rst_y",      va.y, 524);
    chk("rst_hs",     va.HS, 1);
    chk("rst_vs",     va.VS, 1);
    chk("rst_active", va.ACTIVE, 0);
    chk("rst_pix",    va.PIX_EN, 0);
    chk("rst_fcnt",   va.FRAME_CNT, 0);
    chk("rst_ls",     va.LINE_START, 0);
    chk("rst_fs",     va.FRAME_START, 0);
    chk("rst_b_y",    vb.y, 9);
    chk("rst_b_vs",   vb.VS, 1);

    // Release dut_a; first strobe after 2nd edge, position moves on 3rd
    rst_a = 1'b1;
    tick();
    chk("a_pix_e1", va.PIX_EN, 0);
    tick();
    chk("a_pix_e2", va.PIX_EN, 1);
    chk("a_x_e2",   va.x, 799);
    tick();
    chk("a_first_x",      va.x, 0);
    chk("a_first_y",      va.y, 0);
    chk("a_first_active", va.ACTIVE, 1);
    chk("a_first_ls",     va.LINE_START, 1);
    chk("a_first_fs",     va.FRAME_START, 1);
    chk("a_first_fcnt",   va.FRAME_CNT, 1);
    chk("a_first_hs",     va.HS, 1);
    chk("a_pix_e3",       va.PIX_EN, 0);
    tick();
    chk("a_ls_drop", va.LINE_START, 0);
    chk("a_fs_drop", va.FRAME_START, 0);
    chk("a_pix_e4",  va.PIX_EN, 1);
    chk("a_x_hold",  va.x, 0);

    // One full line
    n = 0; hs_low = 0; hs_first = -1; hs_err = 0; act_err = 0;
    while (!(va.x == 0 && va.y == 1) && n < 2000) begin
      tick();
      n++;
      if (va.HS == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(va.x);
      end
      if (va.HS !== ((va.x >= 656 && va.x <= 751) ? 1'b0 : 1'b1)) hs_err++;
      if (va.ACTIVE !== (va.x < 640 && va.y < 480)) act_err++;
    end
    chk("line_ticks",    n, 1599);
    chk("hs_low_clks",   hs_low, 192);
    chk("hs_first_x",    hs_first, 656);
    chk("hs_decode_err", hs_err, 0);
    chk("act_decode_err", act_err, 0);
    chk("line_wrap_y",   va.y, 1);
    chk("line_wrap_ls",  va.LINE_START, 1);
    chk("line_wrap_fs",  va.FRAME_START, 0);

    // Asynchronous reset mid-line
    n = 0;
    while (va.x != 300 && n < 2000) begin
      tick();
      n++;
    end
    chk("pre_rst_x", va.x, 300);
    chk("pre_rst_y", va.y, 1);
    #1 rst_a = 1'b0;
    #1;
    chk("arst_x",      va.x, 799);
    chk("arst_y",      va.y, 524);
    chk("arst_hs",     va.HS, 1);
    chk("arst_active", va.ACTIVE, 0);
    chk("arst_pix",    va.PIX_EN, 0);
    chk("arst_fcnt",   va.FRAME_CNT, 0);
    chk("arst_ls",     va.LINE_START, 0);
    tick();
    tick();
    rst_a = 1'b1;
    tick();
    tick();
    tick();
    chk("rerst_x",    va.x, 0);
    chk("rerst_y",    va.y, 0);
    chk("rerst_fs",   va.FRAME_START, 1);
    chk("rerst_fcnt", va.FRAME_CNT, 1);

    // CLK_DIV=1 unit: continuous strobe, full frames
    rst_b = 1'b1;
    tick();
    chk("b_pix_e1", vb.PIX_EN, 1);
    chk("b_x_e1",   vb.x, 799);
    tick();
    chk("b_first_x",    vb.x, 0);
    chk("b_first_y",    vb.y, 0);
    chk("b_first_fs",   vb.FRAME_START, 1);
    chk("b_first_fcnt", vb.FRAME_CNT, 1);

    n = 0; pz = 0; vs_low = 0; vs_err = 0; ls_cnt = 0; ls1 = -1; ls2 = -1;
    act_cnt = 0; y_last = int'(vb.y);
    while (!(vb.FRAME_START && vb.FRAME_CNT == 8'd2) && n < 10000) begin
      y_last = int'(vb.y);
      tick();
      n++;
      if (!vb.PIX_EN) pz++;
      if (!vb.VS) vs_low++;
      if (vb.VS !== ((vb.y == 6 || vb.y == 7) ? 1'b0 : 1'b1)) vs_err++;
      if (vb.ACTIVE) act_cnt++;
      if (vb.LINE_START) begin
        ls_cnt++;
        if (ls1 < 0) ls1 = n;
        else if (ls2 < 0) ls2 = n;
      end
    end
    chk("b_frame_clks",  n, 8000);
    chk("b_pix_gaps",    pz, 0);
    chk("b_vs_low_clks", vs_low, 1600);
    chk("b_vs_decode",   vs_err, 0);
    chk("b_active_clks", act_cnt, 2560);
    chk("b_line_starts", ls_cnt, 10);
    chk("b_first_ls_at", ls1, 800);
    chk("b_line_period", ls2 - ls1, 800);
    chk("b_y_before_wrap", y_last, 9);
    chk("b_wrap_x",      vb.x, 0);
    chk("b_wrap_y",      vb.y, 0);
    chk("b_fcnt2",       vb.FRAME_CNT, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
